// File: rtl/hdmi_rx_capture_if.sv
// Avalon-ST style video source bundle for hdmi_rx_capture.
//
// Handshake: source-only stream. A word transfers on every rising clk edge
// where aso_src_valid_o is 1; there is no ready, so the sink must accept every
// valid word. Data, startofpacket and endofpacket are meaningful only while
// valid is 1.
interface hdmi_rx_capture_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  aso_src_valid_o;
  logic [DATA_WIDTH-1:0] aso_src_data_o;
  logic                  aso_src_startofpacket_o;
  logic                  aso_src_endofpacket_o;

  modport master (
    output aso_src_valid_o,
    output aso_src_data_o,
    output aso_src_startofpacket_o,
    output aso_src_endofpacket_o
  );

  modport slave (
    input aso_src_valid_o,
    input aso_src_data_o,
    input aso_src_startofpacket_o,
    input aso_src_endofpacket_o
  );
endinterface

// File: rtl/hdmi_rx_capture.sv
// HDMI receiver capture: turns a DE/HS/VS pixel bus into a packetised frame
// stream with geometry checking. Optional feature macro: HDMI_RX_MEASURE_EN
// (measured line length / line count on meas_*; constant 0 when undefined).
// Pipeline: inputs registered once, stream outputs registered once, giving two
// clocks from data_enable to valid. dbg_state exposes the FSM.
module hdmi_rx_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int HACTIVE    = 1280,
  parameter int VACTIVE    = 720
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture_en_i,
  input  logic        data_enable,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  data_r,
  input  logic [7:0]  data_g,
  input  logic [7:0]  data_b,
  hdmi_rx_capture_if.master src,
  output logic        frame_done_o,
  output logic        frame_error_o,
  output logic [12:0] meas_hactive_o,
  output logic [12:0] meas_vactive_o,
  output logic [1:0]  dbg_state,
  output logic        dbg_hsync
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_BLANK   = 2'd2;
  localparam logic [1:0] S_ACTIVE  = 2'd3;

  localparam logic [12:0] CNT_MAX = 13'h1FFF;
  localparam logic [12:0] H_LEN   = 13'(HACTIVE);
  localparam logic [12:0] H_LAST  = 13'(HACTIVE - 1);
  localparam logic [12:0] V_LEN   = 13'(VACTIVE);
  localparam logic [12:0] V_LAST  = 13'(VACTIVE - 1);

  logic        de_q, de_qq, hs_q, vs_q, vs_qq;
  logic [7:0]  r_q, g_q, b_q;
  logic [1:0]  state, state_nxt;
  logic [12:0] pix_cnt, line_cnt, pix_idx;
  logic        vs_start, de_rise, de_fall, in_frame;
  logic        emit, sop_emit, eop_emit, line_err, frame_end, frame_bad;
  logic [DATA_WIDTH-1:0] word;
  logic                  valid_q, sop_q, eop_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Register the video bus once; the second vs/de stage only feeds edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q <= 1'b0; de_qq <= 1'b0; hs_q <= 1'b0; vs_q <= 1'b0; vs_qq <= 1'b0;
      r_q  <= '0;   g_q   <= '0;   b_q  <= '0;
    end else begin
      de_q <= data_enable; de_qq <= de_q;
      hs_q <= hsync;
      vs_q <= vsync;       vs_qq <= vs_q;
      r_q  <= data_r;      g_q   <= data_g; b_q <= data_b;
    end
  end

  // Edge events, per-pixel position and stream gating decisions.
  always_comb begin
    vs_start  = vs_qq & ~vs_q;
    de_rise   = de_q & ~de_qq;
    de_fall   = ~de_q & de_qq;
    pix_idx   = de_rise ? 13'd0 : pix_cnt;
    // The first pixel of a frame arrives in the same cycle BLANK hands over to ACTIVE.
    in_frame  = (state == S_ACTIVE) || ((state == S_BLANK) && de_rise);
    emit      = de_q && !vs_start && in_frame && (pix_idx < H_LEN) && (line_cnt < V_LEN);
    sop_emit  = emit && (pix_idx == 13'd0) && (line_cnt == 13'd0);
    eop_emit  = emit && (pix_idx == H_LAST) && (line_cnt == V_LAST);
    // A vsync start masks a coincident data_enable edge.
    line_err  = (state == S_ACTIVE) && de_fall && !vs_start && (pix_cnt != H_LEN);
    frame_end = (state == S_ACTIVE) && vs_start;
    frame_bad = frame_end && (line_cnt != V_LEN);
    word      = '0;
    word[23:0] = {b_q, g_q, r_q};
  end

  // Next-state logic; capture_en_i only matters at a frame boundary (or to leave IDLE).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (capture_en_i) state_nxt = S_WAIT_VS;
      S_WAIT_VS: if (vs_start) state_nxt = capture_en_i ? S_BLANK : S_IDLE;
      S_BLANK: begin
        if (vs_start)     state_nxt = capture_en_i ? S_BLANK : S_IDLE;
        else if (de_rise) state_nxt = S_ACTIVE;
      end
      default:   if (vs_start) state_nxt = capture_en_i ? S_BLANK : S_IDLE;
    endcase
  end

  // FSM state and saturating pixel / line counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (de_q) pix_cnt <= (pix_idx == CNT_MAX) ? CNT_MAX : pix_idx + 13'd1;
      if (vs_start)                            line_cnt <= '0;
      else if (de_fall && line_cnt != CNT_MAX) line_cnt <= line_cnt + 13'd1;
    end
  end

  // Registered stream outputs and frame status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      data_q        <= '0;
      frame_done_o  <= 1'b0;
      frame_error_o <= 1'b0;
    end else begin
      valid_q      <= emit;
      sop_q        <= sop_emit;
      eop_q        <= eop_emit;
      if (emit) data_q <= word;
      frame_done_o <= frame_end && !frame_bad && !frame_error_o;
      if (sop_emit)                  frame_error_o <= 1'b0;
      else if (line_err || frame_bad) frame_error_o <= 1'b1;
    end
  end

`ifdef HDMI_RX_MEASURE_EN
  logic [12:0] max_len;

  // Track the longest line since the last vsync start and publish it with the line count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_len        <= '0;
      meas_hactive_o <= '0;
      meas_vactive_o <= '0;
    end else if (vs_start) begin
      meas_hactive_o <= max_len;
      meas_vactive_o <= line_cnt;
      max_len        <= '0;
    end else if (de_fall && pix_cnt > max_len) begin
      max_len <= pix_cnt;
    end
  end
`else
  assign meas_hactive_o = '0;
  assign meas_vactive_o = '0;
`endif

  assign src.aso_src_valid_o         = valid_q;
  assign src.aso_src_data_o          = data_q;
  assign src.aso_src_startofpacket_o = sop_q;
  assign src.aso_src_endofpacket_o   = eop_q;
  assign dbg_state = state;
  // Registered hsync is visible for debug only; it never gates the stream.
  assign dbg_hsync = hs_q;

endmodule

// File: tb/tb_hdmi_rx_capture.sv
// Self-checking bench for hdmi_rx_capture with a small frame geometry.
// Expected words come from a frame-level model: per captured frame, pixel
// (line l, index p) produces a word when l < V and p < H; SOP at (0,0), EOP at
// (V-1,H-1). Frame outcome: error if any line length != H or line count != V.
module tb_hdmi_rx_capture;
  localparam int DW  = 32;
  localparam int H   = 16;
  localparam int V   = 6;
  localparam int SAT = 8191;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_en_i = 1'b0;
  logic        data_enable = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [7:0]  data_r = '0, data_g = '0, data_b = '0;
  logic        frame_done_o, frame_error_o;
  logic [12:0] meas_hactive_o, meas_vactive_o;
  logic [1:0]  dbg_state;
  logic        dbg_hsync;

  hdmi_rx_capture_if #(.DATA_WIDTH(DW)) src_if ();

  hdmi_rx_capture #(.DATA_WIDTH(DW), .HACTIVE(H), .VACTIVE(V)) dut (
    .clk(clk), .reset_n(reset_n), .capture_en_i(capture_en_i),
    .data_enable(data_enable), .hsync(hsync), .vsync(vsync),
    .data_r(data_r), .data_g(data_g), .data_b(data_b),
    .src(src_if),
    .frame_done_o(frame_done_o), .frame_error_o(frame_error_o),
    .meas_hactive_o(meas_hactive_o), .meas_vactive_o(meas_vactive_o),
    .dbg_state(dbg_state), .dbg_hsync(dbg_hsync)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW+1:0] exp_q[$];   // {sop, eop, word}
  int done_cnt = 0;
  logic [DW+1:0] mon_got, mon_want;

  // Model state
  bit armed = 0, cur_cap = 0, err_flag = 0, f_err = 0, aborted = 0, meas_ok = 0;
  int exp_done = 0, f_lines = 0, f_max = 0, exp_meas_h = 0, exp_meas_v = 0;

  // Per-frame options
  int fr_lines, fr_long_idx, fr_long_len, fr_drop, fr_raise, fr_rst_line, fr_rst_pix;
  bit fr_lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid word must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_done_o) done_cnt++;
      if (src_if.aso_src_valid_o) begin
        mon_got = {src_if.aso_src_startofpacket_o, src_if.aso_src_endofpacket_o,
                   src_if.aso_src_data_o};
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_errors++;
          $error("FAIL unexpected_word got=%0h exp=none", mon_got);
        end
        if (exp_q.size() > 0) begin
          mon_want = exp_q.pop_front();
          n_checks++;
          assert (mon_got === mon_want) else begin
            n_errors++;
            $error("FAIL stream_word got=%0h exp=%0h", mon_got, mon_want);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_opts;
    fr_lines = V; fr_long_idx = -1; fr_long_len = H; fr_drop = -1; fr_raise = -1;
    fr_rst_line = -1; fr_rst_pix = -1; fr_lat = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, src_if.aso_src_valid_o, 0);
    chk({tag, "_data"},  src_if.aso_src_data_o, 0);
    chk({tag, "_sop"},   src_if.aso_src_startofpacket_o, 0);
    chk({tag, "_eop"},   src_if.aso_src_endofpacket_o, 0);
    chk({tag, "_done"},  frame_done_o, 0);
    chk({tag, "_err"},   frame_error_o, 0);
    chk({tag, "_meas_h"}, meas_hactive_o, 0);
    chk({tag, "_meas_v"}, meas_vactive_o, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    cur_cap = 0; armed = 0; err_flag = 0; aborted = 1;
    tick; tick;
    reset_n = 1'b1;
    armed = capture_en_i;
  endtask

  // Frame boundary: close the previous frame in the model, then check its outcome.
  task automatic vs_boundary;
    bit ferr;
    vsync = 1'b0;
    if (cur_cap) begin
      ferr = f_err || (f_lines != V);
      if (ferr) err_flag = 1;
      else exp_done++;
    end
    exp_meas_h = (f_max > SAT) ? SAT : f_max;
    exp_meas_v = f_lines;
    meas_ok = !aborted;
    cur_cap = armed && capture_en_i;
    if (!capture_en_i) armed = 0;
    f_err = 0; f_lines = 0; f_max = 0; aborted = 0;
    tick; tick;
    vsync = 1'b1;
    repeat (4) tick;
    @(negedge clk);
    chk("frame_done_count", done_cnt, exp_done);
    chk("frame_error", frame_error_o, err_flag);
    chk("words_drained", exp_q.size(), 0);
`ifdef HDMI_RX_MEASURE_EN
    if (meas_ok) begin
      chk("meas_hactive", meas_hactive_o, exp_meas_h);
      chk("meas_vactive", meas_vactive_o, exp_meas_v);
    end
`else
    chk("meas_hactive", meas_hactive_o, 0);
    chk("meas_vactive", meas_vactive_o, 0);
`endif
    if (!armed) chk("idle_state", dbg_state, 0);
  endtask

  // Drive one frame: boundary, then lines of pixels with horizontal blanking.
  task automatic drive_frame;
    int len;
    logic [DW-1:0] w;
    vs_boundary();
    for (int l = 0; l < fr_lines; l++) begin
      if (l == fr_drop) capture_en_i = 1'b0;
      if (l == fr_raise) begin capture_en_i = 1'b1; armed = 1; end
      len = (l == fr_long_idx) ? fr_long_len : H;
      for (int p = 0; p < len; p++) begin
        tick;
        if (l == fr_rst_line && p == fr_rst_pix) do_reset();
        if (fr_lat && l == 0 && p == 0) begin
          data_r = 8'h11; data_g = 8'h22; data_b = 8'h33;
        end else begin
          data_r = 8'($urandom); data_g = 8'($urandom); data_b = 8'($urandom);
        end
        data_enable = 1'b1;
        if (cur_cap && l < V && p < H) begin
          w = '0;
          w[23:0] = {data_b, data_g, data_r};
          exp_q.push_back({(l == 0 && p == 0), (l == V-1 && p == H-1), w});
          if (l == 0 && p == 0) err_flag = 0;
        end
        if (fr_lat && l == 0 && p == 1) begin
          @(negedge clk);
          chk("latency_early", src_if.aso_src_valid_o, 0);
        end
        if (fr_lat && l == 0 && p == 2) begin
          @(negedge clk);
          chk("latency_valid", src_if.aso_src_valid_o, 1);
          chk("latency_data", src_if.aso_src_data_o, 32'h0033_2211);
        end
      end
      f_lines++;
      if (len > f_max) f_max = len;
      if (cur_cap && len != H) begin f_err = 1; err_flag = 1; end
      for (int i = 0; i < 4; i++) begin
        tick;
        data_enable = 1'b0;
        hsync = (i != 1);
        if (i == 2 && cur_cap) begin
          @(negedge clk);
          chk("line_end_error", frame_error_o, err_flag);
        end
      end
    end
    repeat (6) tick;
  endtask

  // Directed sequence
  initial begin
    reset_opts();
    for (int i = 0; i < 5; i++) begin
      tick;
      data_enable = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      data_r = 8'($urandom);
    end
    @(negedge clk);
    check_all_zero("reset");
    data_enable = 1'b0; vsync = 1'b1; hsync = 1'b1;
    tick;
    reset_n = 1'b1;
    tick;
    capture_en_i = 1'b1; armed = 1;
    tick; tick;

    reset_opts(); fr_lat = 1;                      drive_frame();  // F1 clean + latency
    reset_opts();                                  drive_frame();  // F2 clean
    reset_opts();                                  drive_frame();  // F3 clean
    reset_opts(); fr_long_idx = 2; fr_long_len = H + 4; drive_frame(); // F4 long line
    reset_opts();                                  drive_frame();  // F5 clean, SOP clears error
    reset_opts(); fr_lines = V - 2;                drive_frame();  // F6 short frame
    reset_opts(); fr_long_idx = 1; fr_long_len = 8300; drive_frame(); // F7 saturating line
    reset_opts(); fr_lines = V + 1;                drive_frame();  // F8 extra line
    reset_opts(); fr_drop = 3;                     drive_frame();  // F9 enable drops mid-frame
    reset_opts(); fr_raise = 1;                    drive_frame();  // F10 not captured
    reset_opts(); fr_rst_line = 2; fr_rst_pix = 5; drive_frame();  // F11 reset mid-frame
    reset_opts();                                  drive_frame();  // F12 clean after reset
    vs_boundary();

    chk("total_frame_done", done_cnt, 6);
    chk("final_error", frame_error_o, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
